// File: rtl/ram_loader_pkg.sv
// Shared types and sizing helpers for the RAM word loader.
package ram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int calc_bytes(input int n, input int byte_w);
        return n / byte_w;
    endfunction

    function automatic int idx_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/ram_word_loader_if.sv
// Byte stream handshake plus RAM write port of the loader.
interface ram_word_loader_if #(
    parameter int N         = 64,
    parameter int ADDR_BITS = 4,
    parameter int BYTE_W    = 8
);
    logic [BYTE_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [N-1:0]         ram_data_in;
    logic                 ram_wr_en;

    modport master (
        output in_data, in_valid,
        input  in_ready, ram_addr, ram_data_in, ram_wr_en
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ram_addr, ram_data_in, ram_wr_en
    );
endinterface

// File: rtl/word_assembler.sv
// Packs consecutive bytes little-endian into one word; last_byte flags the final lane.
module word_assembler
    import ram_loader_pkg::*;
#(
    parameter int N      = 64,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [BYTE_W-1:0] in_data,
    output logic [N-1:0]      word,
    output logic              last_byte
);
    localparam int BYTES = calc_bytes(N, BYTE_W);
    localparam int IDX_W = idx_width(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     word_q, word_d;

    assign last_byte = (idx_q == LAST_IDX);
    assign word      = word_q;

    // Lane write and byte-index advance; old lanes are simply overwritten next word.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clr) begin
            idx_d = '0;
        end else if (load) begin
            word_d[int'(idx_q) * BYTE_W +: BYTE_W] = in_data;
            if (last_byte) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1'b1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Packing register and index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/ram_word_loader.sv
// Fills the whole word RAM from a byte stream, one packed word per address, then pulses done.
module ram_word_loader
    import ram_loader_pkg::*;
#(
    parameter int N         = 64,
    parameter int ADDR_BITS = 4,
    parameter int BYTE_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    ram_word_loader_if.slave     bus,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS:0]   word_count
);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 wr_en_q, wr_en_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 in_ready_s, accept_s, clr_s, last_byte_s;
    logic [N-1:0]         word_s;

    assign in_ready_s = (state_q == COLLECT);
    assign accept_s   = bus.in_valid && in_ready_s;

    word_assembler #(.N(N), .BYTE_W(BYTE_W)) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .load      (accept_s),
        .in_data   (bus.in_data),
        .word      (word_s),
        .last_byte (last_byte_s)
    );

    // Next-state, address and count; strobes are derived from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        clr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    clr_s   = 1'b1;
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s && last_byte_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = COLLECT;
                end
            end
            WRITE: begin
                count_d = count_q + (ADDR_BITS+1)'(1'b1);
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_BITS'(1'b1);
                    state_d = COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wr_en_d = (state_d == WRITE);
        done_d  = (state_d == DONE);
        busy_d  = (state_d == COLLECT) || (state_d == WRITE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_data_in = word_s;
    assign bus.ram_wr_en   = wr_en_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign word_count      = count_q;

endmodule

// File: tb/tb_ram_word_loader.sv
// Scoreboard bench for ram_word_loader: driver pushes expected RAM writes, a negedge monitor checks them.
module tb_ram_word_loader;
    localparam int N     = 64;
    localparam int AB    = 4;
    localparam int BW    = 8;
    localparam int BYTES = N / BW;
    localparam int NW    = 1 << AB;

    typedef struct {
        logic [AB-1:0] addr;
        logic [N-1:0]  data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AB:0]   word_count;

    exp_t          exp_q[$];
    int            exp_done = 0;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            fill_writes = 0;
    int            last_wr_cyc = -10;
    bit            wc_pend = 1'b0;
    int            wc_exp = 0;
    logic [N-1:0]  mem   [NW];
    logic [N-1:0]  model [NW];

    ram_word_loader_if #(.N(N), .ADDR_BITS(AB), .BYTE_W(BW)) bus ();

    ram_word_loader #(.N(N), .ADDR_BITS(AB), .BYTE_W(BW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM that the loader feeds.
    always @(posedge clk) if (bus.ram_wr_en === 1'b1) mem[bus.ram_addr] <= bus.ram_data_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic timeout(input string what);
        n_vec++;
        n_err++;
        $display("FAIL timeout_%s: no progress, expected the DUT to respond", what);
        summary();
    endtask

    // Monitor: every RAM write and done pulse is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (wc_pend) begin
                    check("word_count_after_write", 64'(word_count), 64'(wc_exp));
                    wc_pend = 1'b0;
                end
                if (bus.ram_wr_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write",
                                 bus.ram_addr, bus.ram_data_in);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(bus.ram_addr), 64'(e.addr));
                        check("wr_data", bus.ram_data_in, e.data);
                        check("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
                    end
                    check("in_ready_in_write", 64'(bus.in_ready), 64'(1'b0));
                    fill_writes++;
                    wc_exp  = fill_writes;
                    wc_pend = 1'b1;
                    if (bus.ram_addr == AB'(NW - 1)) last_wr_cyc = cyc;
                end
                if (done === 1'b1) begin
                    if (exp_done == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: done=1, expected 0");
                    end else begin
                        exp_done--;
                    end
                    check("done_after_last_write", 64'(cyc), 64'(last_wr_cyc + 1));
                    check("done_word_count", 64'(word_count), 64'(NW));
                    check("done_busy", 64'(busy), 64'(1'b0));
                end
            end
        end
    end

    task automatic send_byte(input logic [BW-1:0] b, input int stall_pct);
        int guard;
        if (int'($urandom_range(99)) < stall_pct) begin
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1) begin
            guard++;
            if (guard > 50) timeout("in_ready");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // mode 0: byte = stream index; mode 1: random; mode 2: first word 01..08 then random.
    task automatic do_fill(input int mode, input int stall_pct, input int nbytes);
        logic [N-1:0]  wv;
        logic [BW-1:0] b;
        int            w, j, g;
        @(posedge clk);
        #1;
        fill_writes = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1'b1));
        wv = '0;
        for (int i = 0; i < nbytes; i++) begin
            w = i / BYTES;
            j = i % BYTES;
            if (mode == 0)                 b = BW'(i);
            else if (mode == 2 && w == 0)  b = BW'(j + 1);
            else                           b = BW'($urandom_range(255));
            send_byte(b, stall_pct);
            wv[j * BW +: BW] = b;
            if (j == BYTES - 1) begin
                model[w] = wv;
                exp_q.push_back('{AB'(w), wv, cyc});
                if (w == NW - 1) exp_done++;
            end
        end
        if (nbytes == NW * BYTES) begin
            g = 0;
            while (exp_done != 0) begin
                @(negedge clk);
                g++;
                if (g > 20) timeout("done");
            end
            @(posedge clk);
            #1;
            check("idle_in_ready", 64'(bus.in_ready), 64'(1'b0));
            check("idle_busy", 64'(busy), 64'(1'b0));
            check("idle_done", 64'(done), 64'(1'b0));
            check("idle_word_count", 64'(word_count), 64'(NW));
        end
    endtask

    task automatic check_ram();
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < NW; a++) check($sformatf("ram_word%0d", a), mem[a], model[a]);
    endtask

    task automatic start_pulser();
        int g = 0;
        while (!(bus.ram_wr_en === 1'b1 && bus.ram_addr == AB'(3))) begin
            @(negedge clk);
            g++;
            if (g > 2000) timeout("word3");
        end
        #1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_wr_en", 64'(bus.ram_wr_en), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_addr", 64'(bus.ram_addr), 64'(0));
        check("rst_word_count", 64'(word_count), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b0));
        exp_q.delete();
        wc_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Stimulus sequence.
    initial begin
        logic [N-1:0] old_w1;
        logic [N-1:0] w15_ref;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wr_en", 64'(bus.ram_wr_en), 64'(1'b0));
        check("reset_addr", 64'(bus.ram_addr), 64'(0));
        check("reset_data", bus.ram_data_in, 64'(0));
        check("reset_done", 64'(done), 64'(1'b0));
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_word_count", 64'(word_count), 64'(0));
        check("reset_in_ready", 64'(bus.in_ready), 64'(1'b0));
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle20_busy", 64'(busy), 64'(1'b0));
        check("idle20_in_ready", 64'(bus.in_ready), 64'(1'b0));

        do_fill(2, 0, NW * BYTES);
        check("first_word", model[0], 64'h0807060504030201);
        check_ram();

        do_fill(0, 0, NW * BYTES);
        check_ram();
        w15_ref = 64'h7F7E7D7C7B7A7978;
        check("ram_word15_const", mem[NW - 1], w15_ref);

        do_fill(0, 40, NW * BYTES);
        check_ram();

        fork
            do_fill(1, 20, NW * BYTES);
            start_pulser();
        join
        check_ram();

        old_w1 = mem[1];
        do_fill(1, 0, 2 * BYTES);
        check("pre_reset_wr_en", 64'(bus.ram_wr_en), 64'(1'b1));
        async_reset();
        repeat (2) @(posedge clk);
        #1;
        check("no_spurious_write", mem[1], old_w1);

        do_fill(1, 0, 2 * BYTES + 5);
        async_reset();
        do_fill(1, 10, NW * BYTES);
        check_ram();

        summary();
    end

endmodule
